// File: rtl/chong_rung_phim.sv
// chong_rung_phim: push-button debouncer.
// The raw pin is polarity-corrected and then passed through a two-flop
// synchroniser. Each level change on the synchronised signal must hold for
// STABLE_CYC consecutive cycles before it is accepted. A clean debounced
// level and one-cycle press/release strobes are produced, all registered.
module chong_rung_phim #(
    parameter int unsigned STABLE_CYC = 500000,
    parameter int unsigned CNT_W      = 20,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic ckht,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_db,
    output logic pressed,
    output logic released,
    output logic busy
);

    // Debouncer states. The encoding places btn_db in bit 1 and "waiting" in
    // the XOR of the two bits, but outputs are still taken from dedicated
    // registers so that a state-register upset cannot glitch them
    // combinationally.
    typedef enum logic [1:0] {
        ST_REL   = 2'b00,
        ST_W_PRS = 2'b01,
        ST_PRS   = 2'b11,
        ST_W_REL = 2'b10
    } state_t;

    // The candidate is accepted on the cycle the counter already holds
    // STABLE_CYC-1; that cycle is the STABLE_CYC-th consecutive sample.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Polarity-corrected raw input; nothing downstream sees btn_in directly.
    logic pol_s;

    // Synchroniser stages.
    logic s1_r;
    logic s2_r;

    // FSM state, stable-time counter and registered outputs.
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             btn_db_r;
    logic             pressed_r;
    logic             released_r;
    logic             busy_r;

    assign pol_s = btn_in ^ ACTIVE_LOW;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= pol_s;
            s2_r <= s1_r;
        end
    end

    // Qualification FSM with stable-time counter and registered outputs.
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_REL;
            cnt_r      <= CNT_ZERO;
            btn_db_r   <= 1'b0;
            pressed_r  <= 1'b0;
            released_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle; a strobe
            // is always followed by a non-waiting state, so two strobes can
            // never land in consecutive cycles.
            pressed_r  <= 1'b0;
            released_r <= 1'b0;
            case (state_r)
                ST_REL: begin
                    btn_db_r <= 1'b0;
                    if (s2_r) begin
                        state_r <= ST_W_PRS;
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_REL;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end
                end
                ST_W_PRS: begin
                    if (!s2_r) begin
                        // Bounce: back to released, no strobe.
                        state_r  <= ST_REL;
                        cnt_r    <= CNT_ZERO;
                        btn_db_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else if (cnt_r >= LAST_CNT) begin
                        // >= rather than == so a corrupted counter can
                        // never run past the threshold and wrap.
                        state_r   <= ST_PRS;
                        cnt_r     <= CNT_ZERO;
                        btn_db_r  <= 1'b1;
                        pressed_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end else begin
                        state_r  <= ST_W_PRS;
                        cnt_r    <= cnt_r + CNT_ONE;
                        btn_db_r <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                ST_PRS: begin
                    btn_db_r <= 1'b1;
                    if (!s2_r) begin
                        state_r <= ST_W_REL;
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_PRS;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end
                end
                ST_W_REL: begin
                    if (s2_r) begin
                        // Bounce: back to pressed, no strobe.
                        state_r  <= ST_PRS;
                        cnt_r    <= CNT_ZERO;
                        btn_db_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end else if (cnt_r >= LAST_CNT) begin
                        state_r    <= ST_REL;
                        cnt_r      <= CNT_ZERO;
                        btn_db_r   <= 1'b0;
                        released_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        state_r  <= ST_W_REL;
                        cnt_r    <= cnt_r + CNT_ONE;
                        btn_db_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to the safe released state.
                    state_r  <= ST_REL;
                    cnt_r    <= CNT_ZERO;
                    btn_db_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign btn_db   = btn_db_r;
    assign pressed  = pressed_r;
    assign released = released_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_chong_rung_phim.sv
// Testbench for chong_rung_phim (STABLE_CYC=4, CNT_W=3).
// Directed scenarios check the edge-exact timing; a randomized phase compares
// against a run-length model of the debounce rule.
module tb_chong_rung_phim;

    localparam int STABLE = 4;

    logic ckht = 1'b0;
    logic rst_n;
    logic btn_in;
    logic btn_in2;
    logic btn_db, pressed, released, busy;
    logic btn_db2, pressed2, released2, busy2;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: sync pipe plus "how long has s2 disagreed with the
    // debounced level" run counter.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0, m_prs = 1'b0, m_rel = 1'b0, m_busy = 1'b0;
    int   m_run = 0;

    always #5 ckht = ~ckht;

    chong_rung_phim #(.STABLE_CYC(STABLE), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut (
        .ckht(ckht), .rst_n(rst_n), .btn_in(btn_in),
        .btn_db(btn_db), .pressed(pressed), .released(released), .busy(busy)
    );

    chong_rung_phim #(.STABLE_CYC(STABLE), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut2 (
        .ckht(ckht), .rst_n(rst_n), .btn_in(btn_in2),
        .btn_db(btn_db2), .pressed(pressed2), .released(released2), .busy(busy2)
    );

    // Drive btn_in, advance one clock edge, update the model; leaves time at edge+1.
    task automatic tick(input logic v);
        btn_in = v;
        @(posedge ckht);
        #1;
        if (!rst_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
            m_prs = 1'b0; m_rel = 1'b0; m_busy = 1'b0; m_run = 0;
        end else begin
            m_prs = 1'b0;
            m_rel = 1'b0;
            if (m_s2 != m_db) begin
                m_run = m_run + 1;
                if (m_run == STABLE) begin
                    m_db  = ~m_db;
                    m_prs = m_db;
                    m_rel = ~m_db;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_busy = (m_run != 0);
            m_s2 = m_s1;
            m_s1 = v ^ 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b1;
        btn_in = 1'b1;
        btn_in2 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        got = {btn_db, pressed, released, busy};
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_immediate: got %b want 0000", got);
        end
        for (int i = 0; i < 5; i++) begin
            tick(i[0]);
            got = {btn_db, pressed, released, busy};
            n_vec++;
            if (got !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d: got %b want 0000", i, got);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1);
    endtask

    task automatic test_clean_press();
        logic [3:0] got, exp;
        for (int e = 1; e <= 8; e++) begin
            tick(1'b0);
            exp = {e >= 6, e == 6, 1'b0, (e >= 3 && e <= 5)};
            got = {btn_db, pressed, released, busy};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL clean_press edge=%0d {db,p,r,busy}: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        #1;
        got = {btn_db, pressed, released, busy};
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_from_pressed: got %b want 0000", got);
        end
        for (int i = 0; i < 3; i++) begin
            tick(i[0]);
            got = {btn_db, pressed, released, busy};
            n_vec++;
            if (got !== 4'b0000) begin
                n_err++;
                $display("FAIL async_reset_hold cyc=%0d: got %b want 0000", i, got);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1);
    endtask

    task automatic test_bounce();
        logic [3:0] got, exp;
        logic pat [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int n_prs = 0;
        for (int e = 1; e <= 10; e++) begin
            tick(pat[e-1]);
            if (pressed === 1'b1) n_prs++;
            exp = {e >= 9, e == 9, 1'b0, m_busy};
            got = {btn_db, pressed, released, busy};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bounce edge=%0d {db,p,r,busy}: got %b want %b", e, got, exp);
            end
        end
        n_vec++;
        if (n_prs != 1) begin
            n_err++;
            $display("FAIL bounce_strobe_count: got %0d want 1", n_prs);
        end
    endtask

    task automatic test_clean_release();
        logic [3:0] got, exp;
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1);
            exp = {e < 6, 1'b0, e == 6, (e >= 3 && e <= 5)};
            got = {btn_db, pressed, released, busy};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL clean_release edge=%0d {db,p,r,busy}: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] got, exp;
        for (int e = 1; e <= 8; e++) begin
            tick(e == 1 ? 1'b0 : 1'b1);
            exp = {1'b0, 1'b0, 1'b0, e == 3};
            got = {btn_db, pressed, released, busy};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL glitch edge=%0d {db,p,r,busy}: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_qual();
        logic [3:0] got, exp;
        for (int e = 1; e <= 4; e++) tick(1'b0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midq_busy_before_reset: got %b want 1", busy);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            got = {btn_db, pressed, released, busy};
            n_vec++;
            if (got !== 4'b0000) begin
                n_err++;
                $display("FAIL midq_in_reset cyc=%0d: got %b want 0000", i, got);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1'b0);
            exp = {e >= 6, e == 6, 1'b0, (e >= 3 && e <= 5)};
            got = {btn_db, pressed, released, busy};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL midq_requalify edge=%0d {db,p,r,busy}: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_polarity();
        logic [3:0] got, exp;
        btn_in2 = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1'b0);
            exp = {e >= 6, e == 6, 1'b0, (e >= 3 && e <= 5)};
            got = {btn_db2, pressed2, released2, busy2};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL polarity_active_high edge=%0d {db,p,r,busy}: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] got, exp;
        logic v;
        int len;
        for (int r = 0; r < 150; r++) begin
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                tick(v);
                rst_n = 1'b1;
            end
            for (int k = 0; k < len; k++) begin
                tick(v);
                exp = {m_db, m_prs, m_rel, m_busy};
                got = {btn_db, pressed, released, busy};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL random run=%0d k=%0d {db,p,r,busy}: got %b want %b", r, k, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_async_reset();
        test_bounce();
        test_clean_release();
        test_glitch();
        test_reset_mid_qual();
        test_polarity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
